// File: rtl/lion_gate_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lion_pkg
//  Description : Shared types and helpers for the two-gate occupancy counter:
//                sequence FSM state encoding, direction codes and the gate
//                pair each FSM state expects to see.
//  Revision    : 1.0  initial release
// ============================================================================
package lion_pkg;

    // Sequence FSM states, explicitly 3-bit encoded
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_A     = 3'd1,
        IN_AB    = 3'd2,
        IN_B     = 3'd3,
        OUT_B    = 3'd4,
        OUT_AB   = 3'd5,
        OUT_A    = 3'd6,
        WAIT_CLR = 3'd7
    } lion_state_t;

    // Direction of a completed pass
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_IN   = 2'd1;
    localparam logic [1:0] DIR_OUT  = 2'd2;

    // Filtered {a,b} pair that keeps a given state where it is.
    // WAIT_CLR has no resting pair; it is handled separately.
    function automatic logic [1:0] state_pair(input lion_state_t st);
        logic [1:0] p;
        p = 2'b00;
        case (st)
            IN_A,  OUT_A  : p = 2'b10;
            IN_AB, OUT_AB : p = 2'b11;
            IN_B,  OUT_B  : p = 2'b01;
            default       : p = 2'b00;
        endcase
        return p;
    endfunction

    // Both gate bits toggled in the same cycle: never a legal step
    function automatic logic both_changed(input logic [1:0] prev, input logic [1:0] curr);
        return &(prev ^ curr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lion_gate_counter_gate_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gate_filter
//  Description : Two-flop synchroniser followed by a debouncer. The filtered
//                output follows the synchronised input only after the two
//                have disagreed for DEB consecutive cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_filter
    import lion_pkg::*;
#(
    parameter int DEB   = 4,
    parameter int DEB_W = $clog2(DEB + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Two-flop synchroniser for the asynchronous light-gate input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count disagreeing cycles, adopt on the DEB-th, restart on agreement
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == DEB_W'(DEB - 1)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + DEB_W'(1);
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/lion_gate_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lion_gate_counter
//  Description : Two-gate cage occupancy counter. Filters both light gates,
//                decodes complete A->B (entry) and B->A (exit) passes with a
//                four-phase sequence FSM and keeps a saturating count with
//                full/empty flags, event pulses and error pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module lion_gate_counter
    import lion_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 200,
    parameter int DEB       = 4,
    parameter int DEB_W     = $clog2(DEB + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate_a,
    input  logic             gate_b,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             enter_p,
    output logic             exit_p,
    output logic             seq_err_p,
    output logic             sat_err_p,
    output logic             busy
);

    // Reject configurations the counter cannot represent
    generate
        if (MAX_COUNT > (2 ** CNT_W) - 1) begin : g_max_check
            $error("lion_gate_counter: MAX_COUNT does not fit in CNT_W bits");
        end
        if (DEB < 1) begin : g_deb_check
            $error("lion_gate_counter: DEB must be at least 1");
        end
    endgenerate

    logic        a_filt;
    logic        b_filt;
    logic [1:0]  pair;

    lion_state_t state_q;
    lion_state_t state_d;
    logic        busy_q;
    logic [1:0]  dir_d;
    logic        seq_err_d;

    logic [CNT_W-1:0] count_q;
    logic             enter_q;
    logic             exit_q;
    logic             seq_err_q;
    logic             sat_err_q;

    gate_filter #(
        .DEB   (DEB),
        .DEB_W (DEB_W)
    ) u_filter_a (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (gate_a),
        .filt_o (a_filt)
    );

    gate_filter #(
        .DEB   (DEB),
        .DEB_W (DEB_W)
    ) u_filter_b (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (gate_b),
        .filt_o (b_filt)
    );

    assign pair = {a_filt, b_filt};

    // FSM state register; busy is registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state: one gate bit at a time walks the path, two at once is illegal
    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_CLR) begin
            if (pair == 2'b00) begin
                state_d = IDLE;
            end
        end else if (pair != state_pair(state_q)) begin
            if (both_changed(state_pair(state_q), pair)) begin
                state_d = WAIT_CLR;
            end else begin
                case (state_q)
                    IDLE   : state_d = (pair == 2'b10) ? IN_A   : OUT_B;
                    IN_A   : state_d = (pair == 2'b11) ? IN_AB  : IDLE;
                    IN_AB  : state_d = (pair == 2'b01) ? IN_B   : IN_A;
                    IN_B   : state_d = (pair == 2'b00) ? IDLE   : IN_AB;
                    OUT_B  : state_d = (pair == 2'b11) ? OUT_AB : IDLE;
                    OUT_AB : state_d = (pair == 2'b10) ? OUT_A  : OUT_B;
                    OUT_A  : state_d = (pair == 2'b00) ? IDLE   : OUT_AB;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output decode: completed pass direction and illegal-transition flag
    always_comb begin
        dir_d     = DIR_NONE;
        seq_err_d = 1'b0;
        if (state_q != WAIT_CLR) begin
            if (pair != state_pair(state_q) && both_changed(state_pair(state_q), pair)) begin
                seq_err_d = 1'b1;
            end else if (state_q == IN_B && pair == 2'b00) begin
                dir_d = DIR_IN;
            end else if (state_q == OUT_A && pair == 2'b00) begin
                dir_d = DIR_OUT;
            end
        end
    end

    // Saturating occupancy counter; clear wins over a same-cycle pass and its pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            enter_q   <= 1'b0;
            exit_q    <= 1'b0;
            seq_err_q <= 1'b0;
            sat_err_q <= 1'b0;
        end else begin
            enter_q   <= 1'b0;
            exit_q    <= 1'b0;
            sat_err_q <= 1'b0;
            seq_err_q <= seq_err_d;
            if (clear) begin
                count_q <= '0;
            end else if (dir_d == DIR_IN) begin
                if (count_q < CNT_W'(MAX_COUNT)) begin
                    count_q <= count_q + CNT_W'(1);
                    enter_q <= 1'b1;
                end else begin
                    sat_err_q <= 1'b1;
                end
            end else if (dir_d == DIR_OUT) begin
                if (count_q != '0) begin
                    count_q <= count_q - CNT_W'(1);
                    exit_q  <= 1'b1;
                end else begin
                    sat_err_q <= 1'b1;
                end
            end
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CNT_W'(MAX_COUNT));
    assign empty     = (count_q == '0);
    assign enter_p   = enter_q;
    assign exit_p    = exit_q;
    assign seq_err_p = seq_err_q;
    assign sat_err_p = sat_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
